sort_completion_monitor: RTL

SORT_COMPLETION_MONITOR -- requirements
Module: sort_completion_monitor

---
 rtl/sort_mon_pkg.sv | 12 +
 rtl/sort_order_check.sv | 30 +++
 rtl/sort_completion_monitor.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sort_mon_pkg.sv
// Shared definitions for the sort completion monitor: FSM state encoding and counter widths.
package sort_mon_pkg;

  localparam int CYCLE_W  = 32;
  localparam int STABLE_W = 8;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } mon_state_e;

endpackage

// File: rtl/sort_order_check.sv
// Combinational ascending-order check over eight signed elements (equal neighbours allowed).
module sort_order_check
  import sort_mon_pkg::*;
#(
  parameter int ELEM_W = 64
) (
  input  logic [ELEM_W-1:0] i_elem1,
  input  logic [ELEM_W-1:0] i_elem2,
  input  logic [ELEM_W-1:0] i_elem3,
  input  logic [ELEM_W-1:0] i_elem4,
  input  logic [ELEM_W-1:0] i_elem5,
  input  logic [ELEM_W-1:0] i_elem6,
  input  logic [ELEM_W-1:0] i_elem7,
  input  logic [ELEM_W-1:0] i_elem8,
  output logic              o_sorted
);

  logic [7:0][ELEM_W-1:0] w_elem;
  logic [6:0]             w_pair_ok;

  assign w_elem = {i_elem8, i_elem7, i_elem6, i_elem5,
                   i_elem4, i_elem3, i_elem2, i_elem1};

  for (genvar gi = 0; gi < 7; gi++) begin : g_pair
    assign w_pair_ok[gi] = $signed(w_elem[gi]) <= $signed(w_elem[gi+1]);
  end

  assign o_sorted = &w_pair_ok;

endmodule

// File: rtl/sort_completion_monitor.sv
// Watches an 8-element array until it holds a stable ascending order or a timeout expires.
// Optional element-sum preservation check is enabled by defining SORT_MON_CHECKSUM_EN.
module sort_completion_monitor
  import sort_mon_pkg::*;
#(
  parameter int ELEM_W         = 64,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ELEM_W-1:0]  element1,
  input  logic [ELEM_W-1:0]  element2,
  input  logic [ELEM_W-1:0]  element3,
  input  logic [ELEM_W-1:0]  element4,
  input  logic [ELEM_W-1:0]  element5,
  input  logic [ELEM_W-1:0]  element6,
  input  logic [ELEM_W-1:0]  element7,
  input  logic [ELEM_W-1:0]  element8,
  output logic               done,
  output logic               sorted_ok,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count
`ifdef SORT_MON_CHECKSUM_EN
  ,
  output logic               checksum_ok
`endif
);

  logic [7:0][ELEM_W-1:0] w_elem;
  logic [7:0][ELEM_W-1:0] r_elem;
  logic [7:0]             w_same;
  mon_state_e             r_state;
  logic [CYCLE_W-1:0]     r_cycle;
  logic [CYCLE_W-1:0]     r_start;
  logic [STABLE_W-1:0]    r_stable;
  logic                   r_done;
  logic                   r_sorted_ok;
  logic                   r_timeout;
  logic [CYCLE_W-1:0]     r_cycle_count;

  logic                   w_sorted;
  logic                   w_unchanged;
  logic                   w_stable_hit;
  logic                   w_complete;
  logic                   w_timeout_hit;
  logic [STABLE_W-1:0]    w_stable_next;
  logic [CYCLE_W-1:0]     w_run_start;

  assign w_elem = {element8, element7, element6, element5,
                   element4, element3, element2, element1};

  sort_order_check #(.ELEM_W(ELEM_W)) u_order (
    .i_elem1  (element1),
    .i_elem2  (element2),
    .i_elem3  (element3),
    .i_elem4  (element4),
    .i_elem5  (element5),
    .i_elem6  (element6),
    .i_elem7  (element7),
    .i_elem8  (element8),
    .o_sorted (w_sorted)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_same
    assign w_same[gi] = (w_elem[gi] == r_elem[gi]);
  end

  assign w_unchanged   = &w_same;
  assign w_stable_hit  = (r_state == RUN) && w_sorted && w_unchanged;
  assign w_stable_next = w_stable_hit ? (r_stable + STABLE_W'(1)) : '0;
  assign w_complete    = w_stable_hit && (w_stable_next == STABLE_W'(STABLE_CYCLES));
  // When the run is only one cycle long, its start is the current counter value.
  assign w_run_start   = (r_stable == '0) ? r_cycle : r_start;
  assign w_timeout_hit = (r_state == RUN) && !w_complete &&
                         (r_cycle == CYCLE_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_elem        <= '0;
      r_cycle       <= '0;
      r_start       <= '0;
      r_stable      <= '0;
      r_done        <= 1'b0;
      r_sorted_ok   <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_elem   <= w_elem;
      r_stable <= w_stable_next;
      case (r_state)
        RUN: begin
          r_cycle <= r_cycle + CYCLE_W'(1);
          if (w_stable_hit && (r_stable == '0)) begin
            r_start <= r_cycle;
          end
          if (w_complete) begin
            r_state       <= DONE;
            r_done        <= 1'b1;
            r_sorted_ok   <= 1'b1;
            r_cycle_count <= w_run_start;
          end else if (w_timeout_hit) begin
            r_state       <= DONE;
            r_done        <= 1'b1;
            r_timeout     <= 1'b1;
            r_cycle_count <= CYCLE_W'(TIMEOUT_CYCLES);
          end
        end
        default: begin
          r_state <= DONE;
        end
      endcase
    end
  end

  assign done        = r_done;
  assign sorted_ok   = r_sorted_ok;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;

`ifdef SORT_MON_CHECKSUM_EN
  logic [ELEM_W-1:0] w_sum;
  logic [ELEM_W-1:0] w_ref_sum;
  logic [ELEM_W-1:0] r_sum;
  logic              r_sum_pending;
  logic              r_checksum_ok;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 8; i++) begin
      w_sum = w_sum + w_elem[i];
    end
  end

  // Completion can coincide with the capture cycle, so compare against the live sum then.
  assign w_ref_sum = r_sum_pending ? w_sum : r_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum_pending <= 1'b1;
      r_sum         <= '0;
      r_checksum_ok <= 1'b0;
    end else begin
      if (r_sum_pending) begin
        r_sum         <= w_sum;
        r_sum_pending <= 1'b0;
      end
      if (w_complete || w_timeout_hit) begin
        r_checksum_ok <= (w_sum == w_ref_sum);
      end
    end
  end

  assign checksum_ok = r_checksum_ok;
`endif

endmodule
